// File: rtl/dcache_responder.sv
// ============================================================================
// Module   : dcache_responder
// Brief    : Data-cache responder over an internal 64-bit RAM with fixed latency.
//            Optional macro DCACHE_RESPONDER_PIPE_EN accepts a request in RESP.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcache_req_valid_i,
  output logic        dcache_req_ready_o,
  input  logic        dcache_wen_i,
  input  logic [63:0] dcache_wdata_i,
  input  logic [63:0] dcache_addr_i,
  input  logic [1:0]  dcache_wlen_i,
  output logic        dcache_resp_valid_o,
  output logic        dcache_resp_err_o,
  output logic [63:0] dcache_rdata_o
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [63:0] addr_q;
  logic [1:0]  wlen_q;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q;
  logic [63:0] mem_q [DEPTH];

  logic                  w_accept;
  logic                  w_commit;
  logic [63:0]           w_offs;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [2:0]            w_off;
  logic                  w_range_err;
  logic                  w_align_err;
  logic                  w_err;
  logic [7:0]            w_bmask_base;
  logic [7:0]            w_bmask;
  logic [63:0]           w_smask;
  logic [63:0]           w_wshift;
  logic [63:0]           w_rshift;

`ifdef DCACHE_RESPONDER_PIPE_EN
  assign dcache_req_ready_o = ~rst & ((state_q == S_IDLE) | (state_q == S_RESP));
`else
  assign dcache_req_ready_o = ~rst & (state_q == S_IDLE);
`endif

  assign dcache_resp_valid_o = (state_q == S_RESP);
  assign dcache_resp_err_o   = err_q;
  assign dcache_rdata_o      = rdata_q;

  assign w_accept = dcache_req_valid_i & dcache_req_ready_o;
  assign w_commit = (state_q == S_ACCESS) && (cnt_q == 4'd0);

  // Range is checked on the full 64-bit address; the index only uses the low bits.
  assign w_offs      = addr_q - BASE_ADDR;
  assign w_range_err = (addr_q < BASE_ADDR) || (w_offs >= SPAN);
  assign w_idx       = w_offs[DEPTH_LOG2+2:3];
  assign w_off       = addr_q[2:0];

  always_comb begin
    w_align_err  = 1'b0;
    w_bmask_base = 8'h01;
    w_smask      = 64'h0000_0000_0000_00FF;
    case (wlen_q)
      2'd1: begin
        w_align_err  = addr_q[0];
        w_bmask_base = 8'h03;
        w_smask      = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        w_align_err  = |addr_q[1:0];
        w_bmask_base = 8'h0F;
        w_smask      = 64'h0000_0000_FFFF_FFFF;
      end
      2'd3: begin
        w_align_err  = |addr_q[2:0];
        w_bmask_base = 8'hFF;
        w_smask      = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      default: begin
        w_align_err  = 1'b0;
        w_bmask_base = 8'h01;
        w_smask      = 64'h0000_0000_0000_00FF;
      end
    endcase
  end

  assign w_err    = w_range_err | w_align_err;
  assign w_bmask  = w_bmask_base << w_off;
  assign w_wshift = wdata_q << {w_off, 3'b000};
  assign w_rshift = mem_q[w_idx] >> {w_off, 3'b000};
  assign rdata_d  = (wen_q | w_err) ? 64'd0 : (w_rshift & w_smask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_INIT;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (w_accept) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= 64'd0;
      addr_q  <= 64'd0;
      wlen_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        wen_q   <= dcache_wen_i;
        wdata_q <= dcache_wdata_i;
        addr_q  <= dcache_addr_i;
        wlen_q  <= dcache_wlen_i;
      end
      if (w_commit) begin
        rdata_q <= rdata_d;
        err_q   <= w_err;
      end
    end
  end

  // RAM is not reset; a store whose commit edge sees rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && wen_q && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (w_bmask[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_wshift[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_responder.sv
// ============================================================================
// Module   : tb_dcache_responder
// Brief    : Scoreboard bench for dcache_responder (byte-level reference model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_responder;

  localparam int          LAT   = 2;
  localparam int          DL2   = 10;
  localparam logic [63:0] BASE  = 64'h8000_0000;
`ifdef DCACHE_RESPONDER_PIPE_EN
  localparam int          SPACING = LAT + 1;
`else
  localparam int          SPACING = LAT + 2;
`endif

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        wen_i;
  logic [63:0] wdata_i;
  logic [63:0] addr_i;
  logic [1:0]  wlen_i;
  logic        resp_valid_o;
  logic        resp_err_o;
  logic [63:0] rdata_o;

  dcache_responder #(
    .DEPTH_LOG2 (DL2),
    .BASE_ADDR  (BASE),
    .LATENCY    (LAT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dcache_req_valid_i  (valid_i),
    .dcache_req_ready_o  (ready_o),
    .dcache_wen_i        (wen_i),
    .dcache_wdata_i      (wdata_i),
    .dcache_addr_i       (addr_i),
    .dcache_wlen_i       (wlen_i),
    .dcache_resp_valid_o (resp_valid_o),
    .dcache_resp_err_o   (resp_err_o),
    .dcache_rdata_o      (rdata_o)
  );

  typedef struct {
    string       tag;
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model[longint];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model works byte by byte on a sparse byte store.
  function automatic void model_req(input logic wen, input logic [63:0] addr,
                                    input logic [1:0] wlen, input logic [63:0] wdata,
                                    output logic err, output logic [63:0] rd);
    int nbytes = 1 << wlen;
    logic [63:0] lim = BASE + 64'd8 * 64'd1024;
    err = (addr < BASE) || (addr >= lim) || ((addr & 64'(nbytes - 1)) != 64'd0);
    rd  = 64'd0;
    if (!err) begin
      for (int i = 0; i < nbytes; i++) begin
        if (wen) model[longint'(addr) + i] = wdata[8*i +: 8];
        else     rd[8*i +: 8] = model.exists(longint'(addr) + i) ? model[longint'(addr) + i] : 8'hxx;
      end
    end
  endfunction

  // Drives one request; returns the edge number at which it was accepted.
  task automatic issue(input string tag, input logic wen, input logic [63:0] addr,
                       input logic [1:0] wlen, input logic [63:0] wdata,
                       input bit expect_resp, output int acc);
    exp_t e;
    bit   ok = 1'b0;
    valid_i = 1'b1;
    wen_i   = wen;
    addr_i  = addr;
    wlen_i  = wlen;
    wdata_i = wdata;
    acc     = -1;
    for (int k = 0; k < 50; k++) begin
      if (ready_o === 1'b1) begin
        ok  = 1'b1;
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
      valid_i = 1'b0;
      return;
    end
    if (expect_resp) begin
      e.tag = tag;
      model_req(wen, addr, wlen, wdata, e.err, e.rdata);
      e.cyc = acc + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    valid_i = 1'b0;
    wen_i   = 1'($urandom);
    addr_i  = {$urandom, $urandom};
    wlen_i  = 2'($urandom);
    wdata_i = {$urandom, $urandom};
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_err"}, {63'd0, resp_err_o}, {63'd0, e.err});
        chk({e.tag, "_rdata"}, rdata_o, e.rdata);
        chk({e.tag, "_latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int acc4[4];
    rst     = 1'b1;
    valid_i = 1'b0;
    wen_i   = 1'b0;
    wdata_i = 64'd0;
    addr_i  = 64'd0;
    wlen_i  = 2'd0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {63'd0, ready_o}, 64'd0);
      chk("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
    end
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_err", {63'd0, resp_err_o}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {63'd0, ready_o}, 64'd1);

    issue("st_dw",      1'b1, 64'h8000_0010, 2'd3, 64'h1122334455667788, 1'b1, a);
    issue("ld_dw",      1'b0, 64'h8000_0010, 2'd3, 64'd0, 1'b1, a);
    issue("st_b",       1'b1, 64'h8000_0013, 2'd0, 64'hDEAD_BEEF_0000_00AB, 1'b1, a);
    issue("ld_dw2",     1'b0, 64'h8000_0010, 2'd3, 64'd0, 1'b1, a);
    issue("ld_b",       1'b0, 64'h8000_0013, 2'd0, 64'd0, 1'b1, a);
    issue("ld_h",       1'b0, 64'h8000_0016, 2'd1, 64'd0, 1'b1, a);
    issue("ld_w",       1'b0, 64'h8000_0014, 2'd2, 64'd0, 1'b1, a);
    issue("st_h",       1'b1, 64'h8000_0014, 2'd1, 64'hFFFF_FFFF_FFFF_5AC3, 1'b1, a);
    issue("ld_dw3",     1'b0, 64'h8000_0010, 2'd3, 64'd0, 1'b1, a);
    issue("ld_w_mis",   1'b0, 64'h8000_0012, 2'd2, 64'd0, 1'b1, a);
    issue("st_w_mis",   1'b1, 64'h8000_0011, 2'd2, 64'hCAFE_F00D, 1'b1, a);
    issue("ld_dw4",     1'b0, 64'h8000_0010, 2'd3, 64'd0, 1'b1, a);
    issue("st_top",     1'b1, 64'h8000_1FF8, 2'd3, 64'h0102030405060708, 1'b1, a);
    issue("st_h_low",   1'b1, 64'h7FFF_FFFE, 2'd1, 64'h0000_0000_0000_EEEE, 1'b1, a);
    issue("ld_top",     1'b0, 64'h8000_1FF8, 2'd3, 64'd0, 1'b1, a);
    issue("ld_b_last",  1'b0, 64'h8000_1FFF, 2'd0, 64'd0, 1'b1, a);
    issue("ld_hi_oor",  1'b0, 64'h8000_2000, 2'd0, 64'd0, 1'b1, a);

    // Dropped load and dropped store: reset lands in the ACCESS window.
    issue("st_base20",  1'b1, 64'h8000_0020, 2'd3, 64'hA5A5_0000_1234_5678, 1'b1, a);
    issue("ld_drop",    1'b0, 64'h8000_0020, 2'd3, 64'd0, 1'b0, a);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue("st_drop",    1'b1, 64'h8000_0020, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, a);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue("ld_after_rst", 1'b0, 64'h8000_0020, 2'd3, 64'd0, 1'b1, a);

    for (int i = 0; i < 4; i++) begin
      issue("ld_b2b", 1'b0, 64'h8000_0010 + 64'(8 * (i % 2)), 2'd3, 64'd0, 1'b1, acc4[i]);
    end
    for (int i = 1; i < 4; i++) begin
      chk("b2b_spacing", 64'(acc4[i] - acc4[i-1]), 64'(SPACING));
    end

    for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
